// File: rtl/exec_alu_pkg.sv
// Shared encodings for the execute-stage integer unit: op classes, per-class op codes, FSM states.
package exec_alu_pkg;

    localparam int XLEN        = 32;
    localparam int IMM_SEL_BIT = 6;

    typedef enum logic [4:0] {
        OPT_ARITH  = 5'd0,
        OPT_MEMORY = 5'd1,
        OPT_BRANCH = 5'd2,
        OPT_JUMP   = 5'd3
    } op_type_e;

    // ARITHMETIC codes occupy op_spec[5:0]; op_spec[6] selects the immediate operand
    typedef enum logic [5:0] {
        ALU_ADD   = 6'd0,
        ALU_SUB   = 6'd1,
        ALU_XOR   = 6'd2,
        ALU_OR    = 6'd3,
        ALU_AND   = 6'd4,
        ALU_SLT   = 6'd5,
        ALU_SLTU  = 6'd6,
        ALU_LUI   = 6'd7,
        ALU_AUIPC = 6'd8,
        ALU_SLL   = 6'd9,
        ALU_SRL   = 6'd10,
        ALU_SRA   = 6'd11
    } alu_op_e;

    typedef enum logic [6:0] {
        BR_BEQ  = 7'd0,
        BR_BNE  = 7'd1,
        BR_BLT  = 7'd2,
        BR_BGE  = 7'd3,
        BR_BLTU = 7'd4,
        BR_BGEU = 7'd5
    } br_op_e;

    typedef enum logic [6:0] {
        JMP_JAL  = 7'd0,
        JMP_JALR = 7'd1
    } jmp_op_e;

    typedef enum logic [6:0] {
        MEM_LOAD  = 7'd0,
        MEM_STORE = 7'd1
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    function automatic logic [XLEN-1:0] align_target(input logic [XLEN-1:0] a);
        return {a[XLEN-1:1], 1'b0};
    endfunction

endpackage

// File: rtl/exec_alu_shift_serial.sv
// Iterative shifter, one bit per cycle; load/abort take effect at the next edge, no backpressure.
// o_value is the value after the current step, so o_done and o_value are captured together.
module exec_alu_shift_serial
    import exec_alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            i_abort,
    input  logic            i_load,
    input  logic [4:0]      i_shamt,
    input  logic [XLEN-1:0] i_value,
    input  logic            i_right,
    input  logic            i_arith,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_value
);

    logic [XLEN-1:0] r_val;
    logic [4:0]      r_cnt;
    logic            r_right;
    logic            r_arith;
    logic [XLEN-1:0] w_step;

    assign w_step  = r_right ? {r_arith & r_val[XLEN-1], r_val[XLEN-1:1]}
                             : {r_val[XLEN-2:0], 1'b0};
    assign o_busy  = (r_cnt != 5'd0);
    assign o_done  = (r_cnt == 5'd1);
    assign o_value = w_step;

    always_ff @(posedge clk) begin
        if (rst || i_abort) begin
            r_val   <= '0;
            r_cnt   <= 5'd0;
            r_right <= 1'b0;
            r_arith <= 1'b0;
        end else if (i_load) begin
            r_val   <= i_value;
            r_cnt   <= i_shamt;
            r_right <= i_right;
            r_arith <= i_arith;
        end else if (o_busy) begin
            r_val <= w_step;
            r_cnt <= r_cnt - 5'd1;
        end
    end

endmodule

// File: rtl/exec_alu.sv
// Execute-stage integer unit: result one cycle after accept (shifts add shamt cycles).
// Output held in HOLD until out_ready; in_ready drops while shifting or while a result is stalled.
module exec_alu
    import exec_alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op_type,
    input  logic [6:0]      op_spec,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd_ind,
    input  logic [XLEN-1:0] pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [4:0]      out_rd_ind,
    output logic            wb_en,
    output logic            br_taken,
    output logic [XLEN-1:0] br_target
);

    state_e          r_state;
    logic            r_out_valid;
    logic [XLEN-1:0] r_result;
    logic [4:0]      r_rd;
    logic            r_wb;
    logic            r_br;
    logic [XLEN-1:0] r_tgt;

    logic [XLEN-1:0] w_b;
    logic [XLEN-1:0] w_res;
    logic [XLEN-1:0] w_tgt;
    logic            w_wb;
    logic            w_br;
    logic            w_shift;
    logic            w_right;
    logic            w_arith;
    logic            w_rd_nz;
    logic            w_sh_start;
    logic            w_accept;
    logic            w_sh_busy;
    logic            w_sh_done;
    logic [XLEN-1:0] w_sh_value;

    always_comb begin
        w_b     = op_spec[IMM_SEL_BIT] ? imm : rs2_val;
        w_rd_nz = (rd_ind != 5'd0);
        w_res   = '0;
        w_tgt   = '0;
        w_wb    = 1'b0;
        w_br    = 1'b0;
        w_shift = 1'b0;
        w_right = 1'b0;
        w_arith = 1'b0;
        case (op_type)
            OPT_ARITH: begin
                w_wb = w_rd_nz;
                case (op_spec[5:0])
                    ALU_ADD:   w_res = rs1_val + w_b;
                    ALU_SUB:   w_res = rs1_val - w_b;
                    ALU_XOR:   w_res = rs1_val ^ w_b;
                    ALU_OR:    w_res = rs1_val | w_b;
                    ALU_AND:   w_res = rs1_val & w_b;
                    ALU_SLT:   w_res = {{(XLEN-1){1'b0}}, $signed(rs1_val) < $signed(w_b)};
                    ALU_SLTU:  w_res = {{(XLEN-1){1'b0}}, rs1_val < w_b};
                    ALU_LUI:   w_res = imm;
                    ALU_AUIPC: w_res = pc + imm;
                    // zero-amount shifts complete like any other op: result is rs1 unchanged
                    ALU_SLL:   begin w_shift = 1'b1; w_res = rs1_val; end
                    ALU_SRL:   begin w_shift = 1'b1; w_right = 1'b1; w_res = rs1_val; end
                    ALU_SRA:   begin w_shift = 1'b1; w_right = 1'b1; w_arith = 1'b1; w_res = rs1_val; end
                    default:   w_wb = 1'b0;
                endcase
            end
            OPT_MEMORY: begin
                if (op_spec == MEM_LOAD || op_spec == MEM_STORE) begin
                    w_res = rs1_val + imm;
                end
            end
            OPT_BRANCH: begin
                w_tgt = align_target(pc + imm);
                case (op_spec)
                    BR_BEQ:  w_br = (rs1_val == rs2_val);
                    BR_BNE:  w_br = (rs1_val != rs2_val);
                    BR_BLT:  w_br = ($signed(rs1_val) <  $signed(rs2_val));
                    BR_BGE:  w_br = ($signed(rs1_val) >= $signed(rs2_val));
                    BR_BLTU: w_br = (rs1_val <  rs2_val);
                    BR_BGEU: w_br = (rs1_val >= rs2_val);
                    default: w_tgt = '0;
                endcase
            end
            OPT_JUMP: begin
                case (op_spec)
                    JMP_JAL: begin
                        w_res = pc + 32'd4;
                        w_tgt = align_target(pc + imm);
                        w_br  = 1'b1;
                        w_wb  = w_rd_nz;
                    end
                    JMP_JALR: begin
                        w_res = pc + 32'd4;
                        w_tgt = align_target(rs1_val + imm);
                        w_br  = 1'b1;
                        w_wb  = w_rd_nz;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign in_ready   = !rst && (r_state == ST_IDLE || (r_state == ST_HOLD && out_ready));
    assign w_accept   = in_valid && in_ready && !flush;
    assign w_sh_start = w_shift && (w_b[4:0] != 5'd0);

    exec_alu_shift_serial u_shift_serial (
        .clk     (clk),
        .rst     (rst),
        .i_abort (flush),
        .i_load  (w_accept && w_sh_start),
        .i_shamt (w_b[4:0]),
        .i_value (rs1_val),
        .i_right (w_right),
        .i_arith (w_arith),
        .o_busy  (w_sh_busy),
        .o_done  (w_sh_done),
        .o_value (w_sh_value)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_rd        <= 5'd0;
            r_wb        <= 1'b0;
            r_br        <= 1'b0;
            r_tgt       <= '0;
        end else if (flush) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_SHIFT: begin
                    if (w_sh_done || !w_sh_busy) begin
                        r_result    <= w_sh_value;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_HOLD;
                    end
                end
                ST_IDLE, ST_HOLD: begin
                    if (in_ready) begin
                        if (in_valid) begin
                            r_result <= w_res;
                            r_rd     <= rd_ind;
                            r_wb     <= w_wb;
                            r_br     <= w_br;
                            r_tgt    <= w_tgt;
                            if (w_sh_start) begin
                                r_state     <= ST_SHIFT;
                                r_out_valid <= 1'b0;
                            end else begin
                                r_state     <= ST_HOLD;
                                r_out_valid <= 1'b1;
                            end
                        end else begin
                            r_state     <= ST_IDLE;
                            r_out_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid  = r_out_valid;
    assign result     = r_result;
    assign out_rd_ind = r_rd;
    assign wb_en      = r_wb;
    assign br_taken   = r_br;
    assign br_target  = r_tgt;

endmodule

// File: tb/tb_exec_alu.sv
// Directed-vector bench for exec_alu with hand-computed expected values.
module tb_exec_alu;
    import exec_alu_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      op_type;
    logic [6:0]      op_spec;
    logic [31:0]     imm;
    logic [31:0]     rs1_val;
    logic [31:0]     rs2_val;
    logic [4:0]      rd_ind;
    logic [31:0]     pc;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     result;
    logic [4:0]      out_rd_ind;
    logic            wb_en;
    logic            br_taken;
    logic [31:0]     br_target;

    int n_tests = 0;
    int n_fail  = 0;

    exec_alu dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op_type    (op_type),
        .op_spec    (op_spec),
        .imm        (imm),
        .rs1_val    (rs1_val),
        .rs2_val    (rs2_val),
        .rd_ind     (rd_ind),
        .pc         (pc),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .out_rd_ind (out_rd_ind),
        .wb_en      (wb_en),
        .br_taken   (br_taken),
        .br_target  (br_target)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] ot, input logic [6:0] os, input logic [31:0] im,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] p);
        op_type  = ot;
        op_spec  = os;
        imm      = im;
        rs1_val  = a;
        rs2_val  = b;
        rd_ind   = rd;
        pc       = p;
        in_valid = 1'b1;
    endtask

    initial begin
        logic seen;
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        op_type = '0; op_spec = '0; imm = '0; rs1_val = '0; rs2_val = '0; rd_ind = '0; pc = '0;
        tick(); tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_wb_en",     {31'd0, wb_en}, 32'd0);
        chk("rst_br_taken",  {31'd0, br_taken}, 32'd0);
        chk("rst_result",    result, 32'd0);
        chk("rst_br_target", br_target, 32'd0);
        chk("rst_rd",        {27'd0, out_rd_ind}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        #1;
        chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

        // ADD 5+7 -> rd3, one cycle latency
        drive(OPT_ARITH, {1'b0, ALU_ADD}, 32'd0, 32'd5, 32'd7, 5'd3, 32'd0);
        tick();
        in_valid = 1'b0;
        chk("add_valid",  {31'd0, out_valid}, 32'd1);
        chk("add_result", result, 32'd12);
        chk("add_wb",     {31'd0, wb_en}, 32'd1);
        chk("add_rd",     {27'd0, out_rd_ind}, 32'd3);
        tick();
        chk("add_drain",  {31'd0, out_valid}, 32'd0);

        // SRA imm 4 on 0x80000000: busy 4 cycles then sign-filled result
        drive(OPT_ARITH, {1'b1, ALU_SRA}, 32'd4, 32'h8000_0000, 32'd0, 5'd5, 32'd0);
        tick();
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("sra_busy_rdy", {31'd0, in_ready}, 32'd0);
            chk("sra_busy_vld", {31'd0, out_valid}, 32'd0);
            in_valid = 1'b0;
            tick();
        end
        chk("sra_valid",  {31'd0, out_valid}, 32'd1);
        chk("sra_result", result, 32'hF800_0000);
        chk("sra_rd",     {27'd0, out_rd_ind}, 32'd5);
        tick();

        // Back-to-back branches, one result per cycle
        drive(OPT_BRANCH, BR_BLT, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 32'd1, 5'd9, 32'h100);
        tick();
        chk("blt_valid",  {31'd0, out_valid}, 32'd1);
        chk("blt_taken",  {31'd0, br_taken}, 32'd1);
        chk("blt_target", br_target, 32'h0000_00F8);
        chk("blt_wb",     {31'd0, wb_en}, 32'd0);
        drive(OPT_BRANCH, BR_BGE, 32'h10, 32'hFFFF_FFFF, 32'd1, 5'd9, 32'h200);
        tick();
        chk("bge_valid",  {31'd0, out_valid}, 32'd1);
        chk("bge_taken",  {31'd0, br_taken}, 32'd0);
        chk("bge_target", br_target, 32'h210);
        drive(OPT_BRANCH, BR_BGEU, 32'h0, 32'hFFFF_FFFF, 32'd1, 5'd9, 32'h300);
        tick();
        chk("bgeu_taken", {31'd0, br_taken}, 32'd1);
        drive(OPT_ARITH, {1'b0, ALU_SLT}, 32'd0, 32'hFFFF_FFFF, 32'd1, 5'd4, 32'h0);
        tick();
        chk("slt_result", result, 32'd1);
        drive(OPT_ARITH, {1'b0, ALU_SLTU}, 32'd0, 32'hFFFF_FFFF, 32'd1, 5'd4, 32'h0);
        tick();
        chk("sltu_result", result, 32'd0);
        drive(OPT_JUMP, JMP_JALR, 32'd0, 32'h203, 32'd0, 5'd0, 32'h400);
        tick();
        chk("jalr_target", br_target, 32'h202);
        chk("jalr_result", result, 32'h404);
        chk("jalr_wb",     {31'd0, wb_en}, 32'd0);
        chk("jalr_taken",  {31'd0, br_taken}, 32'd1);
        drive(OPT_JUMP, JMP_JAL, 32'h10, 32'd0, 32'd0, 5'd1, 32'h200);
        tick();
        chk("jal_target", br_target, 32'h210);
        chk("jal_result", result, 32'h204);
        chk("jal_wb",     {31'd0, wb_en}, 32'd1);
        drive(OPT_MEMORY, MEM_LOAD, 32'h10, 32'h1000, 32'd0, 5'd6, 32'h0);
        tick();
        chk("mem_result", result, 32'h1010);
        chk("mem_wb",     {31'd0, wb_en}, 32'd0);
        drive(5'd9, 7'd0, 32'h10, 32'h1234, 32'd5, 5'd6, 32'h40);
        tick();
        chk("undef_valid",  {31'd0, out_valid}, 32'd1);
        chk("undef_result", result, 32'd0);
        chk("undef_wb",     {31'd0, wb_en}, 32'd0);
        chk("undef_taken",  {31'd0, br_taken}, 32'd0);
        drive(OPT_ARITH, {1'b1, ALU_SLL}, 32'd0, 32'h0000_00A5, 32'd0, 5'd2, 32'h0);
        tick();
        in_valid = 1'b0;
        chk("sll0_valid",  {31'd0, out_valid}, 32'd1);
        chk("sll0_result", result, 32'h0000_00A5);
        tick();

        // Stall: ADD held for 3 cycles, next op accepted on release
        out_ready = 1'b0;
        drive(OPT_ARITH, {1'b0, ALU_ADD}, 32'd0, 32'd1, 32'd2, 5'd7, 32'h0);
        tick();
        drive(OPT_ARITH, {1'b0, ALU_SUB}, 32'd0, 32'd10, 32'd3, 5'd1, 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk("stall_valid",  {31'd0, out_valid}, 32'd1);
            chk("stall_result", result, 32'd3);
            chk("stall_rd",     {27'd0, out_rd_ind}, 32'd7);
            chk("stall_rdy",    {31'd0, in_ready}, 32'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("release_rdy", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("release_valid",  {31'd0, out_valid}, 32'd1);
        chk("release_result", result, 32'd7);
        chk("release_rd",     {27'd0, out_rd_ind}, 32'd1);
        tick();

        // Flush beats a same-cycle acceptance in IDLE
        flush = 1'b1;
        drive(OPT_ARITH, {1'b0, ALU_ADD}, 32'd0, 32'd1, 32'd1, 5'd3, 32'h0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_idle_vld", {31'd0, out_valid}, 32'd0);
        tick();
        chk("flush_idle_vld2", {31'd0, out_valid}, 32'd0);

        // Flush mid SLL shamt=20 together with a new in_valid
        drive(OPT_ARITH, {1'b1, ALU_SLL}, 32'd20, 32'd1, 32'd0, 5'd8, 32'h0);
        tick();
        in_valid = 1'b0;
        tick(); tick();
        flush = 1'b1;
        drive(OPT_ARITH, {1'b0, ALU_ADD}, 32'd0, 32'd4, 32'd4, 5'd2, 32'h0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        chk("flush_shift_no_vld", {31'd0, seen}, 32'd0);
        chk("flush_shift_idle_rdy", {31'd0, in_ready}, 32'd1);

        // Reset mid shift clears all outputs
        drive(OPT_ARITH, {1'b1, ALU_SRL}, 32'd10, 32'hFFFF_0000, 32'd0, 5'd9, 32'h0);
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("rstmid_valid",  {31'd0, out_valid}, 32'd0);
        chk("rstmid_result", result, 32'd0);
        chk("rstmid_rd",     {27'd0, out_rd_ind}, 32'd0);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        chk("rstmid_no_vld", {31'd0, seen}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/exec_alu.md
# exec_alu

Execute-stage integer unit that consumes decoded instructions (op_type, op_spec, imm, register indices) plus operand values and produces a registered result, write-back control and branch resolution. It sits between the decode stage and the memory/write-back stages. Upstream and downstream use valid/ready handshakes. Shifts run on an iterative shifter, so the block stalls upstream while one is in progress.

## Interface
- XLEN, 32, datapath width
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  decoded instruction present
- in_ready  out  1  block accepts instruction this cycle
- op_type  in  5  operation class (ARITHMETIC, MEMORY, BRANCH, JUMP)
- op_spec  in  7  specific op; for ARITHMETIC, bit 6 = immediate operand select
- imm  in  XLEN  assembled sign-extended immediate
- rs1_val, rs2_val  in  XLEN  register operand values
- rd_ind  in  5  destination register index
- pc  in  XLEN  instruction address
- flush  in  1  discard in-flight and pending work
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- result  out  XLEN  ALU result / link value / memory address
- out_rd_ind  out  5  destination index, registered with result
- wb_en  out  1  result is written to rd
- br_taken  out  1  control transfer taken
- br_target  out  XLEN  redirect address, bit 0 always 0

## Operation
- Operand B = op_spec[6] ? imm : rs2_val for ARITHMETIC; all arithmetic is modulo 2^XLEN.
- ARITHMETIC: ADD, SUB, XOR, OR, AND, SLT (signed), SLTU, LUI (result = imm), AUIPC (result = pc+imm). wb_en = (rd_ind != 0).
- SLL/SRL/SRA: shamt = B[4:0], one bit per cycle on the sub-shifter. SRA replicates bit XLEN-1.
- MEMORY: result = rs1_val+imm (address), wb_en = 0, br_taken = 0.
- BRANCH: BEQ/BNE/BLT/BGE (signed)/BLTU/BGEU compare rs1_val vs rs2_val. br_target = pc+imm, br_taken = condition, wb_en = 0.
- JAL: result = pc+4, br_taken = 1, br_target = pc+imm. JALR: br_target = (rs1_val+imm) & ~1. wb_en = (rd_ind != 0).
- Undefined op_type/op_spec: result 0, wb_en 0, br_taken 0; out_valid still asserts, so the pipeline does not hang.
- FSM states:
  - IDLE: accept on in_valid. Shift with shamt != 0 goes to SHIFT; all other ops go to HOLD.
  - SHIFT: decrement count each cycle; at count 0 go to HOLD.
  - HOLD: out_valid = 1. On out_ready, go to IDLE, or accept a new op the same cycle.
- in_ready = !rst && (state == IDLE || (state == HOLD && out_ready)).
- All outputs stay stable in HOLD until the handshake completes.

## Timing
- Reset: state IDLE; out_valid, wb_en and br_taken 0; result, br_target and out_rd_ind 0.
- Non-shift op accepted in cycle N: out_valid high in cycle N+1.
- Shift with shamt k: out_valid high in cycle N+1+k (k = 0 behaves as non-shift).
- Back-to-back non-shift ops with out_ready held high: one result per cycle.
- flush: takes effect the next cycle. State goes to IDLE, out_valid goes to 0, and a shift is aborted.
- flush has priority over an acceptance in the same cycle; that instruction is dropped.
- rst mid-shift: same as flush, plus all outputs return to reset values.
- out_ready while out_valid = 0: ignored.

## Structure
- op_type and op_spec encodings (including LUI, AUIPC and JALR codes) live in the shared types package. No local literals.
- Sub-module shift_serial: load, shamt, direction/arith inputs; busy/done/value outputs.
- Comparator and adder stay inline.

## Test plan
- Reset, then ADD rs1=5, rs2=7, rd=3 with out_ready=1 -> next cycle result=12, wb_en=1, out_rd_ind=3.
- SRA imm shamt=4 on 0x80000000 -> in_ready=0 for 4 cycles, then result=0xF8000000 in cycle N+5.
- BLT rs1=-1, rs2=1, pc=0x100, imm=-8 -> br_taken=1, br_target=0xF8, wb_en=0.
- JALR rd=0, rs1=0x203, imm=0 -> br_target=0x202, result=pc+4, wb_en=0.
- out_ready=0 for 3 cycles after ADD -> outputs stable and in_ready=0; on release, next op accepted the same cycle.
- flush during SLL shamt=20 together with a new in_valid -> out_valid never rises, and the new op is not accepted.
